// File: rtl/multi_display_scanner.sv
// Time-multiplexed 7-segment scanner: buffered hex digits, leading-zero blanking, PWM dimming.
// seg/dp/enable are registered one clock after the index/buffer/PWM state they show.
module multi_display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 250_000,
  parameter int DIM_BITS   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5*NUM_DIGITS-1:0] digits,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lzb_en,
  input  logic [DIM_BITS-1:0]     brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   enable,
  output logic                    frame_tick
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [NUM_DIGITS-1:0][4:0] buf_q;
  logic [SW-1:0]              slot_cnt;
  logic [IW-1:0]              idx;
  logic [DIM_BITS-1:0]        pwm_cnt;
  logic [4:0]                 cur;
  logic [NUM_DIGITS:0]        lz_chain;
  logic                       lit;
  logic [NUM_DIGITS-1:0]      en_nxt;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  assign cur = buf_q[idx];

  // A digit is a leading zero only if it and every digit above it are 0 without DP.
  always_comb begin
    lz_chain = '0;
    lz_chain[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_chain[i] = (buf_q[i] == 5'd0) && lz_chain[i+1];
    end
  end

  assign lit = !blank_mask[idx] && !(lzb_en && lz_chain[idx]) && (pwm_cnt <= brightness);

  always_comb begin
    en_nxt = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lit && (idx == IW'(i))) en_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q      <= '0;
      slot_cnt   <= '0;
      idx        <= '0;
      pwm_cnt    <= '0;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      enable     <= '1;
      frame_tick <= 1'b0;
    end else begin
      if (load) buf_q <= digits;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      frame_tick <= (slot_cnt == SLOT_LAST) && (idx == IDX_LAST);
      seg        <= lit ? hex_to_seg(cur[3:0]) : 7'b1111111;
      dp         <= lit ? ~cur[4] : 1'b1;
      enable     <= en_nxt;
    end
  end
endmodule

// File: doc/multi_display_scanner.md
MULTI_DISPLAY_SCANNER -- requirements
Module: multi_display_scanner

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 SHALL have parameter SCAN_DIV, default 250_000, clocks per digit slot (legal >= 2).
REQ-003 SHALL have parameter DIM_BITS, default 4, brightness/PWM counter width (legal 1..8).
REQ-004 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port digits  input  5*NUM_DIGITS  per digit i: bits [5i+3:5i] hex value, bit 5i+4 decimal point.
REQ-007 SHALL have port load  input  1  capture strobe for digits into the display buffer.
REQ-008 SHALL have port blank_mask  input  NUM_DIGITS  1 = force digit i dark.
REQ-009 SHALL have port lzb_en  input  1  1 = leading-zero blanking enabled.
REQ-010 SHALL have port brightness  input  DIM_BITS  duty-cycle setting.
REQ-011 SHALL have port seg  output  7  {g,f,e,d,c,b,a}, active-low, registered.
REQ-012 SHALL have port dp  output  1  decimal point, active-low, registered.
REQ-013 SHALL have port enable  output  NUM_DIGITS  one-cold digit anode enables, active-low, registered.
REQ-014 SHALL have port frame_tick  output  1  one-clock pulse when the scan wraps to digit 0.

Function
REQ-015 SHALL hold a display buffer of 5*NUM_DIGITS bits, loaded from digits on every clock where load=1; it holds otherwise; the display shows buffer contents only.
REQ-016 SHALL run slot counter 0..SCAN_DIV-1; at SCAN_DIV-1 it returns to 0 and the digit index advances by 1.
REQ-017 SHALL wrap the digit index NUM_DIGITS-1 -> 0 and assert frame_tick for exactly that clock.
REQ-018 SHALL run a free DIM_BITS-bit PWM counter incrementing every clock, wrapping all-ones -> 0.
REQ-019 SHALL light the selected digit only while pwm_cnt <= brightness (brightness 0 = 1/2^DIM_BITS duty; all-ones = 100%).
REQ-020 SHALL decode hex 0-F to standard segments (0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110 in {g..a}).
REQ-021 SHALL, with lzb_en=1, blank each digit i>0 whose value is 0 with DP=0 and all higher digits also so blanked; digit 0 is never leading-zero blanked.
REQ-022 SHALL drive a dark digit as enable bit high, seg=1111111, dp=1 (dark = blank_mask, leading-zero, or PWM off-phase).
REQ-023 SHALL drive exactly one enable bit low when lit, none low when dark; never two low.
REQ-024 SHALL register seg, dp, enable: they reflect index/buffer/PWM state with exactly 1 clock latency.
REQ-025 SHALL give load precedence: a buffer change during a slot is visible 1 clock after capture (plus REQ-024 latency), without resetting slot or index.
REQ-026 SHALL treat brightness and blank_mask changes as taking effect on the next clock (no synchronisation inside the block).

Reset
REQ-027 SHALL, on reset low, immediately clear slot counter, PWM counter, index and buffer to 0, set seg=1111111, dp=1, enable all ones, frame_tick=0.
REQ-028 SHALL resume scanning from digit 0, slot 0, on the first rising clk after reset deasserts; reset mid-slot discards the partial slot.

Verification (NUM_DIGITS=4, SCAN_DIV=4, DIM_BITS=2 unless stated)
REQ-029 SHALL cover reset: assert reset mid-scan -> outputs dark asynchronously, after release enable sequence 1110,1101,1011,0111 each 4 clocks, frame_tick once per 16 clocks.
REQ-030 SHALL cover decode/DP: load digits {D3..D0}={1,0,8,F}, D2 DP=1, brightness=3 -> digit0 seg=0001110, digit1 0000000, digit2 1000000 dp=0, digit3 1111001.
REQ-031 SHALL cover leading-zero blanking: load {0,0,0,0}, lzb_en=1 -> only digit 0 lit (1000000); load {0,5,0,0} -> digits 0..2 lit, digit 3 dark.
REQ-032 SHALL cover PWM: brightness=0 -> each digit enabled 1 clock in 4; brightness=2 -> 3 in 4; blank_mask=0100 -> digit 2 never enabled.
REQ-033 SHALL cover load behaviour: change digits with load=0 -> display unchanged; pulse load mid-slot -> new seg value 2 clocks after load edge, index timing undisturbed.
